// File: rtl/conv_window_sequencer.sv
// Window sequencer for the 2x2 conv/sobel accumulator: fetches a 4x4 window,
// streams it with {mode, k} tags, post-processes the four sums and returns them.
module conv_window_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_DATA_W = 13,
  parameter int ADDR_W     = 12,
  parameter int IMG_W      = 64
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_start,
  input  logic                    i_mode,
  input  logic [ADDR_W-1:0]       i_base_addr,
  output logic                    o_busy,
  output logic                    o_mem_cen,
  output logic [ADDR_W-1:0]       o_mem_addr,
  input  logic [DATA_WIDTH-1:0]   i_mem_rdata,
  output logic                    o_acc_clear,
  output logic [DATA_WIDTH-1:0]   o_acc_data,
  output logic [4:0]              o_acc_coe_mode_addr,
  input  logic [OUT_DATA_W+3:0]   i_acc_ul,
  input  logic [OUT_DATA_W+3:0]   i_acc_ur,
  input  logic [OUT_DATA_W+3:0]   i_acc_ll,
  input  logic [OUT_DATA_W+3:0]   i_acc_lr,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic [DATA_WIDTH-1:0]   o_out_data,
  output logic [1:0]              o_out_idx
);

  localparam int SUM_W = OUT_DATA_W + 4;
  localparam logic [SUM_W:0] SAT = (SUM_W+1)'((1 << DATA_WIDTH) - 1);

  typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, CAPT, OUT} state_t;

  state_t                 state, next;
  logic                   mode;
  logic [ADDR_W-1:0]      base;
  logic [3:0]             rd_k;
  logic [1:0]             beat;
  logic [DATA_WIDTH-1:0]  res [4];
  logic [ADDR_W-1:0]      rd_addr;

  // row = k[3:2], col = k[1:0]; the sum wraps modulo 2^ADDR_W
  assign rd_addr = base + ADDR_W'(rd_k[3:2] * IMG_W) + ADDR_W'(rd_k[1:0]);

  // Conv: round by /16; sobel: magnitude of a signed sum. The extra bit keeps
  // the negated most-negative sum positive so it saturates too.
  function automatic logic [DATA_WIDTH-1:0] post_proc(input logic [SUM_W-1:0] sum,
                                                      input logic sobel);
    logic [SUM_W:0] ext;
    logic [SUM_W:0] mag;
    ext = {sum[SUM_W-1], sum};
    if (sobel) mag = sum[SUM_W-1] ? -ext : ext;
    else       mag = ({1'b0, sum} + (SUM_W+1)'(8)) >> 4;
    return (mag > SAT) ? '1 : mag[DATA_WIDTH-1:0];
  endfunction

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (i_start) next = CLEAR;
      CLEAR:   next = FEED;
      FEED:    if (rd_k == 4'd15) next = DRAIN;
      DRAIN:   next = CAPT;
      CAPT:    next = OUT;
      OUT:     if (beat == 2'd3 && i_out_ready) next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode <= 1'b0;
      base <= '0;
      rd_k <= '0;
      beat <= '0;
      for (int unsigned i = 0; i < 4; i++) res[i] <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          mode <= i_mode;
          base <= i_base_addr;
          rd_k <= '0;
          beat <= '0;
        end
        CLEAR, FEED: rd_k <= rd_k + 4'd1;
        CAPT: begin
          res[0] <= post_proc(i_acc_ul, mode);
          res[1] <= post_proc(i_acc_ur, mode);
          res[2] <= post_proc(i_acc_ll, mode);
          res[3] <= post_proc(i_acc_lr, mode);
        end
        OUT: if (i_out_ready) beat <= beat + 2'd1;
        default: ;
      endcase
    end
  end

  // Read k is issued one cycle before its data returns, so the tag lags rd_k by one
  always_comb begin
    o_busy              = (state != IDLE);
    o_mem_cen           = 1'b0;
    o_mem_addr          = '0;
    o_acc_clear         = 1'b0;
    o_acc_data          = '0;
    o_acc_coe_mode_addr = '0;
    o_out_valid         = 1'b0;
    o_out_data          = '0;
    o_out_idx           = '0;
    case (state)
      IDLE:  o_acc_clear = 1'b1;
      CLEAR: begin
        o_acc_clear = 1'b1;
        o_mem_cen   = 1'b1;
        o_mem_addr  = rd_addr;
      end
      FEED: begin
        o_mem_cen           = 1'b1;
        o_mem_addr          = rd_addr;
        o_acc_data          = i_mem_rdata;
        o_acc_coe_mode_addr = {mode, rd_k - 4'd1};
      end
      DRAIN: begin
        o_acc_data          = i_mem_rdata;
        o_acc_coe_mode_addr = {mode, 4'd15};
      end
      CAPT:  o_acc_coe_mode_addr = {mode, 4'd0};
      OUT: begin
        o_out_valid = 1'b1;
        o_out_data  = res[beat];
        o_out_idx   = beat;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_conv_window_sequencer.sv
// Bench for conv_window_sequencer: SRAM and accumulator models around the DUT,
// with address and result-beat scoreboards.
module tb_conv_window_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        mode = 1'b0;
  logic [11:0] base_addr = '0;
  logic        busy, mem_cen, acc_clear, out_valid;
  logic [11:0] mem_addr;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  acc_data, out_data;
  logic [4:0]  acc_tag;
  logic [16:0] acc_ul, acc_ur, acc_ll, acc_lr;
  logic        out_ready = 1'b1;
  logic [1:0]  out_idx;

  conv_window_sequencer #(.DATA_WIDTH(8), .OUT_DATA_W(13), .ADDR_W(12), .IMG_W(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_base_addr(base_addr),
    .o_busy(busy), .o_mem_cen(mem_cen), .o_mem_addr(mem_addr), .i_mem_rdata(mem_rdata),
    .o_acc_clear(acc_clear), .o_acc_data(acc_data), .o_acc_coe_mode_addr(acc_tag),
    .i_acc_ul(acc_ul), .i_acc_ur(acc_ur), .i_acc_ll(acc_ll), .i_acc_lr(acc_lr),
    .o_out_valid(out_valid), .i_out_ready(out_ready), .o_out_data(out_data), .o_out_idx(out_idx)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Accumulator weights per output (ul, ur, ll, lr) and window position k
  int cw [4][16] = '{
    '{1,2,1,0, 2,4,2,0, 1,2,1,0, 0,0,0,0},
    '{0,0,0,0, 1,2,1,0, 2,4,2,0, 1,2,1,0},
    '{0,0,0,0, 4,4,4,4, 0,0,0,0, 0,0,0,0},
    '{2,2,2,2, 2,2,2,2, 0,0,0,0, 0,0,0,0}};
  int sw [4][16] = '{
    '{ 0, 0,0, 0, 2,0,-2, 0, 0,1,0,-1, 0,0,0, 0},
    '{ 0, 0,0, 0, 1,1,-1,-1, 0,0,0, 0, 0,0,0, 0},
    '{-2,-1,0, 0, 0,0, 0, 0, 2,1,0, 0, 0,0,0, 0},
    '{ 1, 0,0,-1, 0,0, 0, 0, 0,0,0, 0, 1,0,0,-1}};

  logic [7:0] mem [4096];
  always @(posedge clk) if (mem_cen) mem_rdata <= mem[mem_addr];

  int acc [4] = '{0, 0, 0, 0};
  always @(posedge clk) begin
    for (int o = 0; o < 4; o++) begin
      if (acc_clear) acc[o] <= 0;
      else acc[o] <= acc[o] + (acc_tag[4] ? sw[o][acc_tag[3:0]] : cw[o][acc_tag[3:0]]) * int'(acc_data);
    end
  end
  assign acc_ul = 17'(acc[0]);
  assign acc_ur = 17'(acc[1]);
  assign acc_ll = 17'(acc[2]);
  assign acc_lr = 17'(acc[3]);

  typedef struct { int idx; int data; } beat_t;
  beat_t exp_q [$];
  int    addr_q [$];
  int    pix [16];
  int    handshakes = 0;
  int    t_start = 0;
  bit    timing_on = 1'b0;
  bit    prev_valid = 1'b0;
  bit    prev_busy = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (start && !busy) t_start = cyc;
      if (mem_cen) begin
        if (addr_q.size() == 0) check("read_unexpected", int'(mem_addr), -1);
        else check("mem_addr", int'(mem_addr), addr_q.pop_front());
      end
      if (out_valid) begin
        if (exp_q.size() == 0) check("beat_unexpected", int'(out_data), -1);
        else begin
          check("out_idx", int'(out_idx), exp_q[0].idx);
          check("out_data", int'(out_data), exp_q[0].data);
          if (out_ready) begin
            void'(exp_q.pop_front());
            handshakes++;
          end
        end
      end
      if (timing_on && out_valid && !prev_valid) check("first_valid_latency", cyc - t_start, 19);
      if (timing_on && !busy && prev_busy) check("busy_fall", cyc - t_start, 23);
      prev_valid = out_valid;
      prev_busy  = busy;
    end else begin
      prev_valid = 1'b0;
      prev_busy  = 1'b0;
    end
  end

  function automatic int ref_px(input int s, input bit sobel);
    int m;
    if (sobel) m = (s < 0) ? -s : s;
    else       m = (s + 8) / 16;
    return (m > 255) ? 255 : m;
  endfunction

  task automatic push_beats(input int ul, input int ur, input int ll, input int lr);
    exp_q.push_back('{0, ul});
    exp_q.push_back('{1, ur});
    exp_q.push_back('{2, ll});
    exp_q.push_back('{3, lr});
  endtask

  task automatic push_model(input bit sobel);
    int s [4];
    for (int o = 0; o < 4; o++) begin
      s[o] = 0;
      for (int k = 0; k < 16; k++) s[o] += (sobel ? sw[o][k] : cw[o][k]) * pix[k];
    end
    push_beats(ref_px(s[0], sobel), ref_px(s[1], sobel), ref_px(s[2], sobel), ref_px(s[3], sobel));
  endtask

  task automatic load_window(input int base);
    for (int k = 0; k < 16; k++) mem[(base + (k / 4) * 8 + k % 4) % 4096] = 8'(pix[k]);
  endtask

  task automatic set_uniform(input int v);
    for (int k = 0; k < 16; k++) pix[k] = v;
  endtask

  task automatic set_single(input int kk, input int v);
    for (int k = 0; k < 16; k++) pix[k] = (k == kk) ? v : 0;
  endtask

  task automatic set_random();
    for (int k = 0; k < 16; k++) pix[k] = int'($urandom_range(0, 255));
  endtask

  // Called at posedge+1 while idle; scrambles mode/base afterwards to show they are latched
  task automatic start_window(input bit m, input int base);
    for (int k = 0; k < 16; k++) addr_q.push_back((base + (k / 4) * 8 + k % 4) % 4096);
    start = 1'b1;
    mode = m;
    base_addr = 12'(base);
    @(posedge clk); #1;
    start = 1'b0;
    mode = ~m;
    base_addr = 12'($urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 100 && busy; i++) begin @(posedge clk); #1; end
    if (busy) check("idle_timeout", int'(busy), 0);
    @(posedge clk); #1;
  endtask

  task automatic run_window(input bit m, input int base);
    load_window(base);
    start_window(m, base);
    wait_idle();
  endtask

  task automatic check_reset_values();
    check("rst_busy", int'(busy), 0);
    check("rst_mem_cen", int'(mem_cen), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_mem_addr", int'(mem_addr), 0);
    check("rst_acc_data", int'(acc_data), 0);
    check("rst_acc_tag", int'(acc_tag), 0);
    check("rst_out_data", int'(out_data), 0);
    check("rst_out_idx", int'(out_idx), 0);
    check("rst_acc_clear", int'(acc_clear), 1);
  endtask

  initial begin
    #2;
    check_reset_values();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Conv uniform 100 with exact latency checks
    timing_on = 1'b1;
    set_uniform(100);
    push_beats(100, 100, 100, 100);
    run_window(1'b0, 100);
    timing_on = 1'b0;

    // Conv single pixel; base 10 also exercises the address sequence
    set_single(4, 200);
    push_beats(25, 13, 50, 25);
    run_window(1'b0, 10);

    set_single(4, 200);
    push_beats(255, 200, 0, 0);
    run_window(1'b1, 300);

    // Sobel, top-left pixel only; base at the top of memory wraps the addresses
    set_single(0, 100);
    push_beats(0, 0, 200, 100);
    run_window(1'b1, 4095);

    set_uniform(77);
    push_beats(0, 0, 0, 0);
    run_window(1'b1, 500);

    // Backpressure on beat 1, start pulses during OUT and on the final handshake
    begin
      int hs0;
      set_random();
      push_model(1'b0);
      load_window(700);
      out_ready = 1'b0;
      start_window(1'b0, 700);
      for (int i = 0; i < 40 && !out_valid; i++) begin @(posedge clk); #1; end
      if (!out_valid) check("valid_timeout", int'(out_valid), 1);
      hs0 = handshakes;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
        start = (i == 2);
        @(posedge clk); #1;
        check("busy_during_out", int'(busy), 1);
      end
      start = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      check("busy_after_final", int'(busy), 0);
      repeat (3) @(posedge clk);
      #1 check("start_not_queued", int'(busy), 0);
      check("handshakes", handshakes - hs0, 4);
    end

    // Reset during FEED (k = 10) with a full-scale window, then a clean window
    set_uniform(255);
    load_window(1000);
    start_window(1'b0, 1000);
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    addr_q.delete();
    #1 check_reset_values();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    set_single(4, 200);
    push_beats(25, 13, 50, 25);
    run_window(1'b0, 2000);

    // Random windows against the reference model
    for (int t = 0; t < 4; t++) begin
      bit m;
      int b;
      m = 1'(t);
      b = int'($urandom_range(0, 4095));
      set_random();
      push_model(m);
      run_window(m, b);
    end

    check("beats_left", exp_q.size(), 0);
    check("reads_left", addr_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule
